// File: rtl/sram_like_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: owner tags, FSM states
// and SRAM-like transfer size codes.
package sram_like_req_arbiter_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// Parameterised 1-bit synchronous FIFO used for in-order tag tracking.
// A push is accepted when full only if a pop frees the head slot in the same cycle.
module owner_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_req_arbiter.sv
// Fixed-priority (data over inst) arbiter with starvation guard that merges two
// SRAM-like requesters onto one master port and routes responses in issue order.
module sram_like_req_arbiter
    import sram_like_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [2:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        resp_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e  state;
    arb_state_e  state_next;
    logic        gnt_valid;
    logic        gnt_owner;
    logic        sel_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_head;
    logic        push;
    logic        pop;
    logic [SW-1:0] starve_cnt;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    // Grant is chosen combinationally in IDLE and frozen while locked.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_owner  = OWNER_INST;
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (data_req && !(inst_req && starve_cnt == SW'(STARVE_LIMIT))) begin
                    gnt_valid = 1'b1;
                    gnt_owner = OWNER_DATA;
                end else if (inst_req) begin
                    gnt_valid = 1'b1;
                    gnt_owner = OWNER_INST;
                end
                if (m_req && !m_addr_ok) begin
                    state_next = (gnt_owner == OWNER_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
                end
            end
            ST_LOCK_INST: begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_INST;
                if (push) state_next = ST_IDLE;
            end
            ST_LOCK_DATA: begin
                gnt_valid = 1'b1;
                gnt_owner = OWNER_DATA;
                if (push) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        m_wr    = 1'b0;
        m_size  = '0;
        m_addr  = '0;
        m_wdata = '0;
        sel_req = 1'b0;
        if (gnt_valid) begin
            if (gnt_owner == OWNER_DATA) begin
                sel_req = data_req;
                m_wr    = data_wr;
                m_size  = data_size;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                sel_req = inst_req;
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    // A response retiring this cycle frees a slot for a same-cycle push.
    assign pop   = !rst && m_data_ok && !fifo_empty;
    assign m_req = !rst && gnt_valid && sel_req && (!fifo_full || pop);
    assign push  = m_req && m_addr_ok;

    assign inst_addr_ok = push && (gnt_owner == OWNER_INST);
    assign data_addr_ok = push && (gnt_owner == OWNER_DATA);
    assign inst_data_ok = pop && (fifo_head == OWNER_INST);
    assign data_data_ok = pop && (fifo_head == OWNER_DATA);
    assign inst_rdata   = inst_data_ok ? m_rdata : inst_rdata_q;
    assign data_rdata   = data_data_ok ? m_rdata : data_rdata_q;

    owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (gnt_owner),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt   <= '0;
            resp_err     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (!inst_req || (push && gnt_owner == OWNER_INST)) begin
                starve_cnt <= '0;
            end else if (push && gnt_owner == OWNER_DATA && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (m_data_ok && fifo_empty) resp_err <= 1'b1;
            if (inst_data_ok) inst_rdata_q <= m_rdata;
            if (data_data_ok) data_rdata_q <= m_rdata;
        end
    end

endmodule
